// File: rtl/multicore_debug_cmd_arbiter.sv
// Round-robin arbiter that lets one of four cores at a time own a shared debug
// slave: latch the winner's command, strobe it, wait for completion or timeout, ack.
module multicore_debug_cmd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*38-1:0]  req_cmd,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic [31:0]            rsp_data,
    output logic                   cmd_valid,
    output logic [37:0]            cmd_data,
    output logic [1:0]             cmd_src,
    input  logic                   mon_ready,
    input  logic                   mon_error,
    input  logic [31:0]            mon_data,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    localparam int CMD_W = 38;
    localparam int SRC_W = 2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         timer_q, timer_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]   cmd_data_q, cmd_data_d;
    logic [SRC_W-1:0]   cmd_src_q, cmd_src_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W-1:0]   idx;

    // First requester at or above ptr, wrapping modulo the core count.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + SRC_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        err_d       = err_q;
        rsp_data_d  = rsp_data_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
        cmd_src_d   = cmd_src_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = ISSUE;
                    cmd_data_d  = req_cmd[int'(sel)*CMD_W +: CMD_W];
                    cmd_src_d   = sel;
                    gnt_d       = ONE << sel;
                    cmd_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                // A completion on the last timer cycle beats the timeout.
                if (mon_ready) begin
                    rsp_data_d = mon_data;
                    err_d      = mon_error;
                    ack_d      = ONE << cmd_src_q;
                    state_d    = RESP;
                end else if (timer_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    err_d      = 1'b1;
                    ack_d      = ONE << cmd_src_q;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                ptr_d   = cmd_src_q + SRC_W'(1);
                gnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rsp_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            cmd_src_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rsp_data_q  <= rsp_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            cmd_src_q   <= cmd_src_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rsp_data  = rsp_data_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_src   = cmd_src_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicore_debug_cmd_arbiter.sv
// Transaction-level bench for the debug command arbiter: scripted and random
// transactions, expectations derived from the arbitration and timing rules.
module tb_multicore_debug_cmd_arbiter;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [151:0] req_cmd;
    logic         mon_ready;
    logic         mon_error;
    logic [31:0]  mon_data;
    logic [3:0]   gnt;
    logic [3:0]   ack;
    logic         err;
    logic [31:0]  rsp_data;
    logic         cmd_valid;
    logic [37:0]  cmd_data;
    logic [1:0]   cmd_src;
    logic         busy;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    logic [1:0] exp_q[$];

    multicore_debug_cmd_arbiter #(.NUM_REQ(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd),
        .gnt(gnt), .ack(ack), .err(err), .rsp_data(rsp_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_src(cmd_src),
        .mon_ready(mon_ready), .mon_error(mon_error), .mon_data(mon_data),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference rule: first set request bit scanning upward from ptr, modulo 4.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
        check({tag, "_cmd_src"}, 64'(cmd_src), 64'd0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("gap_busy", 64'(busy), 64'd0);
            req = 4'b0000;
        end
    endtask

    task automatic scramble_cmds();
        for (int i = 0; i < 4; i++) req_cmd[i*38 +: 38] = {6'($urandom()), 32'($urandom())};
    endtask

    // One full transaction starting in an IDLE cycle. delay = WAIT cycle index
    // on which mon_ready rises (>= TMO means never).
    task automatic do_txn(input logic [3:0] r, input int delay, input bit drop,
                          input bit rdy_issue, input bit ebit,
                          input bit use_fixed, input logic [37:0] fixed_cmd,
                          input logic [31:0] fixed_data, output logic [1:0] obs_src);
        logic [37:0] cmds[4];
        logic [37:0] exp_cmd;
        logic        exp_err;
        logic [31:0] exp_rsp;
        logic [31:0] d;
        bit          done;
        int          w;
        int          k;

        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_gnt", 64'(gnt), 64'd0);
        check("idle_ack", 64'(ack), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cmds[i] = use_fixed ? fixed_cmd : {6'($urandom()), 32'($urandom())};
            req_cmd[i*38 +: 38] = cmds[i];
        end
        req = r;
        mon_ready = 1'b0;
        w = pick(r, m_ptr);
        exp_cmd = cmds[w];

        @(negedge clk);
        obs_src = cmd_src;
        check("issue_cmd_valid", 64'(cmd_valid), 64'd1);
        check("issue_gnt", 64'(gnt), 64'(1) << w);
        check("issue_cmd_src", 64'(cmd_src), 64'(w));
        check("issue_cmd_data", 64'(cmd_data), 64'(exp_cmd));
        check("issue_busy", 64'(busy), 64'd1);
        check("issue_ack", 64'(ack), 64'd0);
        scramble_cmds();
        if (drop) req = r & ~(4'b0001 << w);
        else req = 4'($urandom_range(0, 15));
        mon_ready = rdy_issue;
        mon_error = 1'b1;
        mon_data  = $urandom();

        done = 1'b0;
        k = 0;
        exp_err = 1'b0;
        exp_rsp = '0;
        while (!done) begin
            @(negedge clk);
            check("wait_cmd_valid", 64'(cmd_valid), 64'd0);
            check("wait_ack", 64'(ack), 64'd0);
            check("wait_gnt", 64'(gnt), 64'(1) << w);
            check("wait_cmd_data", 64'(cmd_data), 64'(exp_cmd));
            check("wait_cmd_src", 64'(cmd_src), 64'(w));
            check("wait_busy", 64'(busy), 64'd1);
            scramble_cmds();
            if (k == delay) begin
                d = use_fixed ? fixed_data : $urandom();
                mon_ready = 1'b1;
                mon_data  = d;
                mon_error = ebit;
                exp_err   = ebit;
                exp_rsp   = d;
                done      = 1'b1;
            end else begin
                mon_ready = 1'b0;
                mon_data  = $urandom();
                mon_error = 1'b1;
                if (k == TMO - 1) begin
                    exp_err = 1'b1;
                    exp_rsp = '0;
                    done    = 1'b1;
                end
            end
            k++;
        end

        @(negedge clk);
        check("resp_ack", 64'(ack), 64'(1) << w);
        check("resp_err", 64'(err), 64'(exp_err));
        check("resp_rsp_data", 64'(rsp_data), 64'(exp_rsp));
        check("resp_gnt", 64'(gnt), 64'(1) << w);
        check("resp_cmd_valid", 64'(cmd_valid), 64'd0);
        check("resp_busy", 64'(busy), 64'd1);
        mon_ready = 1'b0;
        mon_error = 1'b0;
        m_ptr = (w + 1) % 4;
    endtask

    task automatic reset_mid_wait(input logic [3:0] r);
        @(negedge clk);
        req = r;
        scramble_cmds();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        req = 4'b0000;
        reset = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        check("post_rst_ack", 64'(ack), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0] src;
        reset = 1'b1;
        req = '0;
        req_cmd = '0;
        mon_ready = 1'b0;
        mon_error = 1'b0;
        mon_data = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        m_ptr = 0;

        // Round-robin fairness with all cores requesting.
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, src);
            check("rr_order", 64'(src), 64'(exp_q.pop_front()));
        end

        // Single request, mon_ready on cycle 4.
        do_txn(4'b0010, 2, 1'b0, 1'b0, 1'b0, 1'b1, 38'h15, 32'hCAFE0001, src);
        // Timeout, then completion coinciding with the last timer cycle.
        do_txn(4'b0001, 99, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, src);
        do_txn(4'b0100, TMO - 1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, src);
        // Withdrawal mid-transaction plus a stray mon_ready during ISSUE.
        do_txn(4'b0100, 2, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, src);

        reset_mid_wait(4'b0100);
        do_txn(4'b1000, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, src);
        check("post_rst_src3", 64'(src), 64'd3);
        reset_mid_wait(4'b0010);
        do_txn(4'b1111, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, src);
        check("post_rst_ptr0", 64'(src), 64'd0);

        for (int i = 0; i < 60; i++) begin
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, TMO + 1),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, '0, '0, src);
            idle_gap($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
